// File: rtl/slave_core_responder_if.sv
// Request/response FIFO handshake bundle for slave_core_responder.
//   slave  modport : the responder (reads requests, writes responses)
//   master modport : the FIFO side (supplies requests, accepts responses)
// Signals:
//   i_rreq_empty / o_rreq_ren / i_rreq_bits : receive-request FIFO
//   o_sresp_bits / o_sresp_wen / i_sresp_full : send-response FIFO
interface slave_core_responder_if #(
  parameter int DATA_LINE_WIDTH    = 64,
  parameter int CONTROL_LINE_WIDTH = 6
);
  localparam int W = DATA_LINE_WIDTH + CONTROL_LINE_WIDTH;

  logic         i_rreq_empty;
  logic         o_rreq_ren;
  logic [W-1:0] i_rreq_bits;
  logic [W-1:0] o_sresp_bits;
  logic         o_sresp_wen;
  logic         i_sresp_full;

  modport slave (
    input  i_rreq_empty, i_rreq_bits, i_sresp_full,
    output o_rreq_ren, o_sresp_bits, o_sresp_wen
  );

  modport master (
    output i_rreq_empty, i_rreq_bits, i_sresp_full,
    input  o_rreq_ren, o_sresp_bits, o_sresp_wen
  );
endinterface

// File: rtl/slave_core_responder.sv
// Register-file slave: pulls one request packet from the receive FIFO,
// executes READ / WRITE / NOP / reserved against a small memory and pushes
// one response packet to the send FIFO (none for NOP).
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset
//   bus (slave)  : request/response FIFO handshake
//   o_busy       : high whenever the FSM is not IDLE
//   o_req_count  : requests retired (saturating)
//   o_err_count  : error responses issued (saturating)
// Packet: [W-1:W-2] opcode/status, [W-3:DATA_LINE_WIDTH] address, [DATA_LINE_WIDTH-1:0] data.
module slave_core_responder #(
  parameter int DATA_LINE_WIDTH    = 64,
  parameter int CONTROL_LINE_WIDTH = 6,
  parameter int MEM_DEPTH          = 16,
  parameter int LOG2_MEM_DEPTH     = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  slave_core_responder_if.slave bus,
  output logic                  o_busy,
  output logic [15:0]           o_req_count,
  output logic [7:0]            o_err_count
);
  localparam int W = DATA_LINE_WIDTH + CONTROL_LINE_WIDTH;

  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_WAIT, S_EXEC, S_RESP} state_e;
  typedef enum logic [1:0] {OP_NOP = 2'b00, OP_READ = 2'b01, OP_WRITE = 2'b10, OP_RSVD = 2'b11} op_e;

  state_e state_q, state_d;

  logic [W-1:0]               req_q;
  logic [W-1:0]               resp_q;
  logic [DATA_LINE_WIDTH-1:0] mem_q [MEM_DEPTH];
  logic [15:0]                req_cnt_q;
  logic [7:0]                 err_cnt_q;

  op_e                         op;
  logic [LOG2_MEM_DEPTH-1:0]   addr;
  logic [W-3:DATA_LINE_WIDTH]  addr_f;
  logic [DATA_LINE_WIDTH-1:0]  wdata;

  assign op     = op_e'(req_q[W-1 -: 2]);
  assign addr   = req_q[DATA_LINE_WIDTH +: LOG2_MEM_DEPTH];
  assign addr_f = req_q[W-3:DATA_LINE_WIDTH];
  assign wdata  = req_q[DATA_LINE_WIDTH-1:0];

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic; i_rreq_empty only matters in IDLE
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (!bus.i_rreq_empty) state_d = S_FETCH;
      S_FETCH: state_d = S_WAIT;
      S_WAIT:  state_d = S_EXEC;
      S_EXEC:  state_d = (op == OP_NOP) ? S_IDLE : S_RESP;
      S_RESP:  if (!bus.i_sresp_full) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Moore outputs, plus the RESP write gated by back-pressure
  always_comb begin
    bus.o_rreq_ren  = (state_q == S_FETCH);
    bus.o_sresp_wen = (state_q == S_RESP) && !bus.i_sresp_full;
    o_busy          = (state_q != S_IDLE);
  end

  // Datapath: request capture, memory, response register, counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_q     <= '0;
      resp_q    <= '0;
      req_cnt_q <= '0;
      err_cnt_q <= '0;
      for (int unsigned i = 0; i < MEM_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      case (state_q)
        S_WAIT: req_q <= bus.i_rreq_bits;
        S_EXEC: begin
          case (op)
            OP_READ:  resp_q <= {OP_READ, addr_f, mem_q[addr]};
            OP_WRITE: begin
              mem_q[addr] <= wdata;
              resp_q      <= {OP_WRITE, addr_f, wdata};
            end
            OP_RSVD: begin
              resp_q <= {OP_RSVD, addr_f, {DATA_LINE_WIDTH{1'b0}}};
              if (err_cnt_q != 8'hFF) err_cnt_q <= err_cnt_q + 8'd1;
            end
            default: if (req_cnt_q != 16'hFFFF) req_cnt_q <= req_cnt_q + 16'd1;
          endcase
        end
        S_RESP: if (bus.o_sresp_wen && req_cnt_q != 16'hFFFF) req_cnt_q <= req_cnt_q + 16'd1;
        default: ;
      endcase
    end
  end

  assign bus.o_sresp_bits = resp_q;
  assign o_req_count      = req_cnt_q;
  assign o_err_count      = err_cnt_q;
endmodule

// File: tb/tb_slave_core_responder.sv
module tb_slave_core_responder;
  localparam int DW = 64;
  localparam int CW = 6;
  localparam int W  = DW + CW;
  localparam logic [1:0] NOP = 2'b00, RD = 2'b01, WR = 2'b10, RSV = 2'b11;
  localparam logic [63:0] DBEEF = 64'hDEADBEEF_01234567;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  slave_core_responder_if #(.DATA_LINE_WIDTH(DW), .CONTROL_LINE_WIDTH(CW)) bus ();

  logic        busy;
  logic [15:0] req_count;
  logic [7:0]  err_count;

  slave_core_responder #(
    .DATA_LINE_WIDTH(DW), .CONTROL_LINE_WIDTH(CW), .MEM_DEPTH(16), .LOG2_MEM_DEPTH(4)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus),
    .o_busy(busy), .o_req_count(req_count), .o_err_count(err_count)
  );

  logic [W-1:0] rq [$];   // requests waiting in the modelled receive FIFO
  logic [W-1:0] sb [$];   // expected responses, in order
  int ren_cyc [$];
  int wen_cyc [$];
  int cyc = 0;
  int t0 = 0;
  int n_checks = 0;
  int n_fail = 0;
  int wen_total = 0;
  int exp_total = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Receive FIFO model: data presented after the read-enable cycle
  initial begin
    bus.i_rreq_empty = 1'b1;
    bus.i_rreq_bits  = '0;
    forever begin
      @(negedge clk);
      if (rst_n && bus.o_rreq_ren) begin
        ren_cyc.push_back(cyc);
        if (rq.size() > 0) bus.i_rreq_bits = rq.pop_front();
        else begin
          n_checks++; n_fail++;
          $display("FAIL fifo_underflow: got read enable expected none");
        end
      end
      if (bus.i_rreq_empty && rq.size() != 0) t0 = cyc;
      bus.i_rreq_empty = (rq.size() == 0);
    end
  end

  // Response monitor
  always @(negedge clk) begin
    if (rst_n && bus.o_sresp_wen) begin
      wen_total++;
      wen_cyc.push_back(cyc);
      if (sb.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL unexpected_resp: got %h expected none", bus.o_sresp_bits);
      end else begin
        chk("resp", bus.o_sresp_bits, sb.pop_front());
      end
    end
  end

  task automatic send(input logic [1:0] op, input logic [3:0] a, input logic [63:0] d,
                      input bit has_resp, input logic [63:0] pay);
    rq.push_back({op, a, d});
    if (has_resp) begin
      sb.push_back({op, a, pay});
      exp_total++;
    end
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    repeat (2) @(negedge clk);
    while (!(rq.size() == 0 && bus.i_rreq_empty && !busy) && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (n >= budget) begin
      n_checks++; n_fail++;
      $display("FAIL idle_timeout: got busy after %0d cycles expected idle", n);
    end
    @(negedge clk);
    chk("sb_drained", W'(sb.size()), '0);
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_ren"},   W'(bus.o_rreq_ren),  '0);
    chk({tag, "_wen"},   W'(bus.o_sresp_wen), '0);
    chk({tag, "_busy"},  W'(busy),            '0);
    chk({tag, "_bits"},  bus.o_sresp_bits,    '0);
    chk({tag, "_reqc"},  W'(req_count),       '0);
    chk({tag, "_errc"},  W'(err_count),       '0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    int wb;
    bus.i_sresp_full = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk_zero_outputs("reset");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle_no_req_busy", W'(busy), '0);

    // WRITE then READ of the same address
    send(WR, 4'h3, DBEEF, 1, DBEEF);
    send(RD, 4'h3, 64'h0, 1, DBEEF);
    wait_idle(100);
    chk("wr_rd_reqc", W'(req_count), W'(16'd2));
    chk("wr_rd_errc", W'(err_count), '0);

    // READ of an unwritten address
    send(RD, 4'hF, 64'h0, 1, 64'h0);
    wait_idle(100);
    chk("rd_unwritten_reqc", W'(req_count), W'(16'd3));

    // Reserved opcode, NOP, then READ back the reserved address
    send(RSV, 4'h5, 64'h1111_2222_3333_4444, 1, 64'h0);
    send(NOP, 4'h9, 64'h5555_5555_5555_5555, 0, 64'h0);
    send(RD,  4'h5, 64'h0, 1, 64'h0);
    wait_idle(100);
    chk("rsv_nop_errc", W'(err_count), W'(8'd1));
    chk("rsv_nop_reqc", W'(req_count), W'(16'd6));

    // Streaming: 4 queued READs
    ren_cyc.delete();
    wen_cyc.delete();
    send(RD, 4'h3, 64'h0, 1, DBEEF);
    send(RD, 4'hF, 64'h0, 1, 64'h0);
    send(RD, 4'h5, 64'h0, 1, 64'h0);
    send(RD, 4'h3, 64'h0, 1, DBEEF);
    wait_idle(100);
    chk("stream_ren_n", W'(ren_cyc.size()), W'(4));
    chk("stream_wen_n", W'(wen_cyc.size()), W'(4));
    for (int i = 0; i < 4; i++) begin
      if (i < ren_cyc.size()) chk("stream_ren_cyc", W'(ren_cyc[i] - t0), W'(1 + 5 * i));
      if (i < wen_cyc.size()) chk("stream_wen_cyc", W'(wen_cyc[i] - t0), W'(4 + 5 * i));
    end
    chk("stream_reqc", W'(req_count), W'(16'd10));

    // Back-pressure: full held for 10 cycles in RESP
    bus.i_sresp_full = 1'b1;
    wb = wen_total;
    send(RD, 4'h3, 64'h0, 1, DBEEF);
    repeat (6) @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      chk("bp_wen",  W'(bus.o_sresp_wen), '0);
      chk("bp_bits", bus.o_sresp_bits, {RD, 4'h3, DBEEF});
      chk("bp_busy", W'(busy), W'(1));
      @(negedge clk);
    end
    @(posedge clk);
    #1 bus.i_sresp_full = 1'b0;
    wait_idle(100);
    chk("bp_single_write", W'(wen_total - wb), W'(1));
    chk("bp_reqc", W'(req_count), W'(16'd11));

    // Reset during WAIT of a WRITE to addr 2
    wb = wen_total;
    send(WR, 4'h2, 64'hCAFE_F00D_1234_5678, 0, 64'h0);
    n = 0;
    @(negedge clk);
    while (!bus.o_rreq_ren && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) begin
      n_checks++; n_fail++;
      $display("FAIL mid_reset_fetch: got no read enable expected one");
    end
    @(negedge clk);           // now in WAIT
    rst_n = 1'b0;
    #1;
    chk_zero_outputs("midrst");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("midrst_no_write", W'(wen_total - wb), '0);
    send(RD, 4'h2, 64'h0, 1, 64'h0);
    send(RD, 4'h3, 64'h0, 1, 64'h0);
    wait_idle(100);
    chk("midrst_reqc", W'(req_count), W'(16'd2));

    // Error counter saturation
    for (int i = 0; i < 260; i++) send(RSV, 4'h1, 64'(i), 1, 64'h0);
    wait_idle(3000);
    chk("err_sat", W'(err_count), W'(8'hFF));
    chk("err_sat_reqc", W'(req_count), W'(16'd262));

    chk("total_resps", W'(wen_total), W'(exp_total));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
